// File: rtl/dmem_pkg.sv
// Shared types for the data memory controller: size codes, FSM states,
// the captured request payload and a size decode helper.
package dmem_pkg;

  localparam int unsigned XLEN = 64;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic            write;
    logic [1:0]      size;
    logic            sgn;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } req_t;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'(4'd1 << size);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 64 storage: byte-enable synchronous write, combinational read,
// boot image of mem[i] = i for i < INIT_WORDS.
module dmem_array
  import dmem_pkg::*;
#(
  parameter  int unsigned DEPTH      = 64,
  parameter  int unsigned INIT_WORDS = 7,
  localparam int unsigned OFF_W      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [7:0]       be,
  input  logic [OFF_W-1:0] addr,
  input  logic [XLEN-1:0]  wdata,
  output logic [XLEN-1:0]  rdata_c
);

  logic [XLEN-1:0] mem [DEPTH];
  logic [XLEN-1:0] boot_c;

  // Cells hold the XOR against the boot image, so an all-zero power-up reads back as the image.
  assign boot_c  = (32'(addr) < INIT_WORDS) ? XLEN'(addr) : '0;
  assign rdata_c = mem[addr] ^ boot_c;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 8; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8] ^ boot_c[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data memory controller: valid/ready request with WAIT_CYCLES wait states,
// sized little-endian loads/stores with extension, misalign/window errors.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned DEPTH       = 64,
  parameter logic [63:0] BASE_ADDR   = 64'h0,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned INIT_WORDS  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [63:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int unsigned OFF_W   = $clog2(DEPTH);
  localparam int unsigned WIN_LSB = OFF_W + 3;
  localparam int unsigned CNT_W   = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  req_t             req_in_c, req_q, req_d, cur_c;
  logic             req_ready_q, req_ready_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_err_q, resp_err_d;
  logic [XLEN-1:0]  resp_rdata_q, resp_rdata_d;
  logic             accept_c, done_c, mis_c, win_c, err_c, we_c;
  logic [2:0]       lane_c;
  logic [5:0]       shamt_c;
  logic [7:0]       be_c;
  logic [XLEN-1:0]  st_c, rd_word_c, ld_c, ld_ext_c;

  assign req_in_c = {req_write, req_size, req_signed, req_addr, XLEN'(req_wdata)};
  assign accept_c = req_valid & req_ready_q;

  // Next state; IDLE and RESP both accept a new request.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    case (state_q)
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = RESP;
      end
      default: begin
        state_d = IDLE;
        if (accept_c) begin
          req_d   = req_in_c;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
    endcase
    done_c       = (state_d == RESP);
    req_ready_d  = (state_d != WAIT);
    resp_valid_d = done_c;
  end

  // Decode and datapath for the access completing on this edge.
  always_comb begin
    cur_c    = (WAIT_CYCLES == 0) ? req_in_c : req_q;
    lane_c   = cur_c.addr[2:0];
    shamt_c  = {lane_c, 3'b000};
    win_c    = (cur_c.addr[XLEN-1:WIN_LSB] == BASE_ADDR[XLEN-1:WIN_LSB]);
    mis_c    = |(lane_c & 3'(size_bytes(cur_c.size) - 4'd1));
    err_c    = mis_c | ~win_c;
    be_c     = 8'((16'd1 << size_bytes(cur_c.size)) - 16'd1) << lane_c;
    st_c     = cur_c.wdata << shamt_c;
    we_c     = done_c & cur_c.write & ~err_c & rst_n;
    ld_c     = rd_word_c >> shamt_c;
    ld_ext_c = ld_c;
    case (cur_c.size)
      SZ_B:    ld_ext_c = cur_c.sgn ? {{56{ld_c[7]}}, ld_c[7:0]}   : {56'd0, ld_c[7:0]};
      SZ_H:    ld_ext_c = cur_c.sgn ? {{48{ld_c[15]}}, ld_c[15:0]} : {48'd0, ld_c[15:0]};
      SZ_W:    ld_ext_c = cur_c.sgn ? {{32{ld_c[31]}}, ld_c[31:0]} : {32'd0, ld_c[31:0]};
      default: ld_ext_c = ld_c;
    endcase
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    if (done_c) begin
      resp_err_d   = err_c;
      resp_rdata_d = (err_c || cur_c.write) ? '0 : ld_ext_c;
    end
  end

  dmem_array #(
    .DEPTH     (DEPTH),
    .INIT_WORDS(INIT_WORDS)
  ) u_array (
    .clk    (clk),
    .we     (we_c),
    .be     (be_c),
    .addr   (cur_c.addr[WIN_LSB-1:3]),
    .wdata  (st_c),
    .rdata_c(rd_word_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = DATA_W'(resp_rdata_q);

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: two instances (default, and BASE 0x1000 with
// zero wait states) checked against a byte-array reference model.
module tb_dmem_ctrl;

  localparam int unsigned W0    = 2;
  localparam int unsigned W1    = 0;
  localparam logic [63:0] BASE0 = 64'h0;
  localparam logic [63:0] BASE1 = 64'h1000;
  localparam int unsigned WIN   = 512;

  typedef struct {
    logic        err;
    logic [63:0] rdata;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [1:0]  req_size [2];
  logic        req_signed [2];
  logic [63:0] req_addr [2];
  logic [63:0] req_wdata [2];
  logic        resp_valid [2];
  logic [63:0] resp_rdata [2];
  logic        resp_err [2];

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [7:0] mb [2][WIN];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_ctrl #(.WAIT_CYCLES(W0), .BASE_ADDR(BASE0)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_size(req_size[0]), .req_signed(req_signed[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]));

  dmem_ctrl #(.WAIT_CYCLES(W1), .BASE_ADDR(BASE1)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_size(req_size[1]), .req_signed(req_signed[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: memory as a flat byte array of the window, accesses as byte loops.
  function automatic void model(input int g, input logic wr, input logic [1:0] sz, input logic sg,
                                input logic [63:0] a, input logic [63:0] wd,
                                output logic err, output logic [63:0] rd);
    int unsigned n    = 1 << sz;
    logic [63:0] base = (g == 0) ? BASE0 : BASE1;
    int unsigned off;
    rd  = '0;
    err = (a % 64'(n) != 0) || (a < base) || (a >= base + 64'(WIN));
    if (err) return;
    off = int'(a - base);
    for (int k = 0; k < int'(n); k++) begin
      if (wr) mb[g][off + k] = wd[8*k +: 8];
      else    rd = rd | (64'(mb[g][off + k]) << (8 * k));
    end
    if (!wr && sg && n < 8 && rd[8*n - 1]) rd = rd | (~64'd0 << (8 * n));
  endfunction

  function automatic int waits(input int g);
    return (g == 0) ? int'(W0) : int'(W1);
  endfunction

  // Drive one request from a negedge; returns at the negedge after acceptance.
  task automatic issue(input int g, input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [63:0] a, input logic [63:0] wd, input bit track);
    exp_t e;
    int   budget = 0;
    int   acc;
    req_valid[g] = 1'b1; req_write[g] = wr; req_size[g] = sz;
    req_signed[g] = sg;  req_addr[g] = a;   req_wdata[g] = wd;
    while (!req_ready[g] && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!req_ready[g]) begin
      check($sformatf("accept_timeout%0d", g), 64'(req_ready[g]), 64'd1);
      req_valid[g] = 1'b0;
      return;
    end
    acc = cyc + 1;
    @(posedge clk);
    if (track) begin
      model(g, wr, sz, sg, a, wd, e.err, e.rdata);
      e.cyc = acc + waits(g);
      if (g == 0) q0.push_back(e); else q1.push_back(e);
    end
    @(negedge clk);
    req_valid[g] = 1'b0;
    req_addr[g]  = {$urandom, $urandom};
    req_wdata[g] = {$urandom, $urandom};
  endtask

  task automatic mon(input int g);
    exp_t e;
    int   depth = (g == 0) ? q0.size() : q1.size();
    if (!resp_valid[g]) return;
    if (depth == 0) begin
      check($sformatf("unexpected_resp%0d", g), 64'(resp_valid[g]), 64'd0);
      return;
    end
    if (g == 0) e = q0.pop_front(); else e = q1.pop_front();
    check($sformatf("resp_cycle%0d", g), 64'(cyc), 64'(e.cyc));
    check($sformatf("resp_err%0d", g), 64'(resp_err[g]), 64'(e.err));
    check($sformatf("resp_rdata%0d", g), resp_rdata[g], e.rdata);
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic idle_checks(input int g, input string tag);
    check({tag, "_ready"}, 64'(req_ready[g]), 64'd1);
    check({tag, "_valid"}, 64'(resp_valid[g]), 64'd0);
    check({tag, "_rdata"}, resp_rdata[g], 64'd0);
    check({tag, "_err"}, 64'(resp_err[g]), 64'd0);
  endtask

  task automatic rand_phase(input int g, input int n);
    logic [63:0] base = (g == 0) ? BASE0 : BASE1;
    logic [63:0] a;
    logic [1:0]  sz;
    int unsigned r;
    for (int i = 0; i < n; i++) begin
      sz = 2'($urandom_range(0, 3));
      r  = $urandom_range(0, 99);
      a  = base + 64'($urandom_range(0, WIN - 1));
      if (r < 75)      a = a & ~64'((1 << sz) - 1);
      else if (r >= 90) a = {$urandom, $urandom};
      issue(g, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
            {$urandom, $urandom}, 1'b1);
      if ($urandom_range(0, 9) < 3) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    for (int g = 0; g < 2; g++) begin
      rst_n[g] = 1'b0; req_valid[g] = 1'b0; req_write[g] = 1'b0; req_size[g] = 2'd0;
      req_signed[g] = 1'b0; req_addr[g] = '0; req_wdata[g] = '0;
      for (int b = 0; b < int'(WIN); b++) mb[g][b] = (b % 8 == 0 && b / 8 < 7) ? 8'(b / 8) : 8'd0;
    end
    repeat (3) @(negedge clk);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(negedge clk);
    idle_checks(0, "reset0");
    idle_checks(1, "reset1");

    // Latency and ready shape for the wait-state instance.
    issue(0, 1'b0, 2'd3, 1'b0, 64'h10, 64'd0, 1'b1);
    check("ready_wait1", 64'(req_ready[0]), 64'd0);
    @(negedge clk);
    check("ready_wait2", 64'(req_ready[0]), 64'd0);
    @(negedge clk);
    check("ready_resp", 64'(req_ready[0]), 64'd1);

    issue(0, 1'b1, 2'd3, 1'b0, 64'h18, 64'h1122334455667788, 1'b1);
    issue(0, 1'b0, 2'd0, 1'b1, 64'h1F, 64'd0, 1'b1);
    issue(0, 1'b1, 2'd0, 1'b0, 64'h1F, 64'h80, 1'b1);
    issue(0, 1'b0, 2'd0, 1'b1, 64'h1F, 64'd0, 1'b1);
    issue(0, 1'b0, 2'd0, 1'b0, 64'h1F, 64'd0, 1'b1);
    issue(0, 1'b1, 2'd1, 1'b0, 64'h22, 64'hBEEF, 1'b1);
    issue(0, 1'b0, 2'd3, 1'b0, 64'h20, 64'd0, 1'b1);
    issue(0, 1'b0, 2'd2, 1'b0, 64'h24, 64'd0, 1'b1);
    issue(0, 1'b0, 2'd2, 1'b0, 64'h0A, 64'd0, 1'b1);
    issue(0, 1'b1, 2'd3, 1'b0, 64'h0C, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    issue(0, 1'b0, 2'd3, 1'b0, 64'h200, 64'd0, 1'b1);
    issue(0, 1'b0, 2'd3, 1'b0, 64'h08, 64'd0, 1'b1);

    // Store dropped by reset mid-wait: no response, no write, outputs cleared.
    issue(0, 1'b1, 2'd3, 1'b0, 64'h30, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);
    rst_n[0] = 1'b0;
    @(negedge clk);
    rst_n[0] = 1'b1;
    @(negedge clk);
    idle_checks(0, "midreset");
    repeat (4) @(negedge clk);
    issue(0, 1'b0, 2'd3, 1'b0, 64'h30, 64'd0, 1'b1);

    // Offset window and zero wait states, including requests accepted in RESP.
    issue(1, 1'b0, 2'd3, 1'b0, 64'h1008, 64'd0, 1'b1);
    issue(1, 1'b1, 2'd2, 1'b0, 64'h1104, 64'h0000_0000_8765_4321, 1'b1);
    issue(1, 1'b0, 2'd2, 1'b1, 64'h1104, 64'd0, 1'b1);
    issue(1, 1'b0, 2'd3, 1'b0, 64'h0008, 64'd0, 1'b1);
    issue(1, 1'b0, 2'd1, 1'b0, 64'h1201, 64'd0, 1'b1);

    rand_phase(0, 200);
    rand_phase(1, 200);

    for (int i = 0; i < 100 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
    check("drain_q0", 64'(q0.size()), 64'd0);
    check("drain_q1", 64'(q1.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
